instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Upstream neighbour of the single-cycle `controller`: owns the program counter, fetches one instruction per step from instruction memory over a req/ready handshake, and holds it in an instruction register. The `op` and `funct` fields drive `controller` directly. At the end of each execute step it takes `pcsrc` back from `controller` and selects the next PC, either sequential or branch target, with no external adder. Instruction memory may insert wait states, so each instruction takes two or more cycles.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded at reset; bits [1:0] must be 0.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  word-aligned fetch address (= `pc`).
- `imem_rdata`  in  32  instruction word; valid when `imem_ready`=1.
- `imem_ready`  in  1  memory accepts the request and returns data this cycle.
- `pcsrc`  in  1  from `controller`; 1 selects the branch target.
- `ex_stall`  in  1  extends the execute step (for example, a data-memory wait).
- `instr`  out  32  instruction register.
- `op`  out  6  `instr[31:26]`.
- `funct`  out  6  `instr[5:0]`.
- `instr_valid`  out  1  `instr` is live for execute.
- `pc`  out  32  address of the current instruction.
- `pc_plus4`  out  32  `pc`+4.

## Operation
- FSM states: BOOT, FETCH, EXEC.
- BOOT: `imem_req`=0. The state advances to FETCH on the first edge after `rst_n` is released.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`, both held stable until `imem_ready` is high at a rising edge.
  - At that edge: `instr`<=`imem_rdata`, and the state goes to EXEC.
- EXEC:
  - `instr_valid`=1 and `imem_req`=0.
  - If `ex_stall`=1: stay in EXEC, with `instr`, `pc` and `instr_valid` unchanged.
  - If `ex_stall`=0: at the edge, `pc`<=`next_pc` and the state goes to FETCH.
- `next_pc` selection:
  - `pcsrc`=1: `branch_target` = `pc_plus4` + {{14{instr[15]}}, instr[15:0], 2'b00}.
  - `pcsrc`=0: `pc_plus4`.
- `pcsrc` is sampled only at the edge that leaves EXEC. It is ignored in BOOT and FETCH.
- All address arithmetic is 32-bit modulo 2^32:
  - 32'hFFFF_FFFC + 4 wraps to 0.
  - Backward branches wrap the same way.
- `pc[1:0]` is always 0. `imem_rdata` is not checked.
- Reset value of every output:
  - `imem_req`=0, `instr_valid`=0.
  - `imem_addr`=`pc`=`RESET_PC`, `pc_plus4`=`RESET_PC`+4.
  - `instr`=0, so `op`=0 and `funct`=0.
- Reset asserted mid-fetch or mid-execute: all outputs go to their reset values asynchronously and the state returns to BOOT. A pending memory response is dropped.

## Timing
- Minimum instruction time is 2 cycles: FETCH with `imem_ready` high in its first cycle, then one EXEC cycle.
- Each memory wait state adds 1 cycle. Each `ex_stall` cycle adds 1 cycle.
- `op`, `funct`, `pc` and `pc_plus4` are registered or derived from registers, so they change only on clock edges (or reset).
- `controller` must produce `pcsrc` combinationally within the EXEC cycle.
- `instr` is constant while `instr_valid`=1.

## Configuration
- `FETCH_JUMP_EN` defined:
  - Opcode 6'b000010 (`j`) in EXEC forces `next_pc` = {`pc_plus4`[31:28], `instr`[25:0], 2'b00}, regardless of `pcsrc`.
- `FETCH_JUMP_EN` undefined:
  - `j` has no special handling; `next_pc` follows `pcsrc` as for any other opcode.

## Structure
- Shared package `mips_pkg` holds:
  - opcode constants `OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_J`;
  - `fetch_state_t` (BOOT/FETCH/EXEC);
  - width constants `XLEN`=32 and `INSTR_W`=32.
- One sub-module, `next_pc_sel`: purely combinational computation of `pc_plus4`, the branch and jump targets, and the `next_pc` mux.
- The FSM and registers stay in `instr_fetch_unit`.

## Test plan
- **Reset:** `rst_n`=0 for 3 cycles with `RESET_PC`=0.
  - During reset: `imem_req`=0, `pc`=0, `instr_valid`=0.
  - One cycle after release: `imem_req`=1, `imem_addr`=0.
- **Zero-wait fetch:** `imem_ready`=1 and `imem_rdata`=32'h0232_8020 (add) at address 0.
  - Next cycle: `op`=000000, `funct`=100000, `instr_valid`=1 for exactly 1 cycle.
  - Then `imem_addr`=4.
- **Branch taken:** at `pc`=32'h10, `instr`=32'h1000_FFFF (beq, imm -1), `pcsrc`=1.
  - Next `imem_addr`=32'h10.
  - Same case with `pcsrc`=0: next `imem_addr`=32'h14.
- **Wait states and stall:** `imem_ready` held low for 3 cycles.
  - `imem_addr` stays stable for 4 cycles and `instr_valid` stays 0.
  - Then `ex_stall`=1 for 2 cycles: `instr_valid` stays high for 3 cycles and `pc` does not change.
- **Wrap and reset mid-operation:**
  - `pc`=32'hFFFF_FFFC with `pcsrc`=0: next `imem_addr`=0.
  - `rst_n` asserted during FETCH: `imem_req` drops immediately and `pc` returns to `RESET_PC`.
- **`FETCH_JUMP_EN` defined:** `instr`=32'h0800_0040 at `pc`=32'h100 with `pcsrc`=0.
  - Next `imem_addr`=32'h0000_0100.
  - With the macro undefined: 32'h104.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: widths, opcodes and the fetch FSM state type.
package mips_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OP_W    = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC datapath: pc+4, sign-extended branch target, jump target and select mux.
module next_pc_sel
  import mips_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [15:0]     imm16,
  input  logic [25:0]     jidx,
  input  logic            pcsrc,
  input  logic            is_jump,
  output logic [XLEN-1:0] pc_plus4_c,
  output logic [XLEN-1:0] next_pc_c
);

  logic [XLEN-1:0] branch_off;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] jump_target;

  // Modulo-2^32 arithmetic: wrap past 32'hFFFF_FFFC and backward branches is intended.
  assign pc_plus4_c    = pc + XLEN'(4);
  assign branch_off    = {{14{imm16[15]}}, imm16, 2'b00};
  assign branch_target = pc_plus4_c + branch_off;
  assign jump_target   = {pc_plus4_c[31:28], jidx, 2'b00};

  always_comb begin
    next_pc_c = pc_plus4_c;
    if (is_jump) begin
      next_pc_c = jump_target;
    end else if (pcsrc) begin
      next_pc_c = branch_target;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// PC, instruction register and BOOT/FETCH/EXEC sequencer in front of the single-cycle controller.
// Define FETCH_JUMP_EN to let opcode j override pcsrc with the pseudo-direct jump target.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ready,
  input  logic               pcsrc,
  input  logic               ex_stall,
  output logic [INSTR_W-1:0] instr,
  output logic [OP_W-1:0]    op,
  output logic [5:0]         funct,
  output logic               instr_valid,
  output logic [XLEN-1:0]    pc,
  output logic [XLEN-1:0]    pc_plus4
);

  fetch_state_t    state;
  fetch_state_t    next_state;
  logic            load_instr;
  logic            load_pc;
  logic            is_jump;
  logic [XLEN-1:0] next_pc;

  assign imem_addr = pc;
  assign op        = instr[31:26];
  assign funct     = instr[5:0];

`ifdef FETCH_JUMP_EN
  assign is_jump = (op == OP_J);
`else
  assign is_jump = 1'b0;
`endif

  next_pc_sel u_next_pc_sel (
    .pc         (pc),
    .imm16      (instr[15:0]),
    .jidx       (instr[25:0]),
    .pcsrc      (pcsrc),
    .is_jump    (is_jump),
    .pc_plus4_c (pc_plus4),
    .next_pc_c  (next_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
    end else begin
      state <= next_state;
    end
  end

  // pcsrc only matters through load_pc, which fires solely on the edge leaving EXEC.
  always_comb begin
    next_state = state;
    load_instr = 1'b0;
    load_pc    = 1'b0;
    case (state)
      BOOT: next_state = FETCH;
      FETCH: begin
        if (imem_ready) begin
          load_instr = 1'b1;
          next_state = EXEC;
        end
      end
      EXEC: begin
        if (!ex_stall) begin
          load_pc    = 1'b1;
          next_state = FETCH;
        end
      end
      default: next_state = BOOT;
    endcase
  end

  // Handshake flags are registered copies of the upcoming state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= '0;
      pc          <= RESET_PC;
    end else begin
      imem_req    <= (next_state == FETCH);
      instr_valid <= (next_state == EXEC);
      if (load_instr) begin
        instr <= imem_rdata;
      end
      if (load_pc) begin
        pc <= next_pc;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a chained instruction table plus reset sequences.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        pcsrc;
  logic        ex_stall;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;

  int n_tests;
  int n_fail;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .pcsrc       (pcsrc),
    .ex_stall    (ex_stall),
    .instr       (instr),
    .op          (op),
    .funct       (funct),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    int          waits;
    int          stalls;
    logic        pcsrc;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [31:0] next;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge while FETCH is presenting v.pc; returns at the next FETCH.
  task automatic run_vec(input int idx, input vec_t v);
    for (int w = 0; w < v.waits; w++) begin
      imem_ready = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      check($sformatf("v%0d wait req", idx), 32'(imem_req), 32'd1);
      check($sformatf("v%0d wait addr", idx), imem_addr, v.pc);
      check($sformatf("v%0d wait valid", idx), 32'(instr_valid), 32'd0);
      @(negedge clk);
    end
    imem_ready = 1'b1;
    imem_rdata = v.rdata;
    check($sformatf("v%0d fetch req", idx), 32'(imem_req), 32'd1);
    check($sformatf("v%0d fetch addr", idx), imem_addr, v.pc);
    @(negedge clk);
    imem_ready = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    pcsrc = v.pcsrc;
    check($sformatf("v%0d op", idx), 32'(op), 32'(v.op));
    check($sformatf("v%0d funct", idx), 32'(funct), 32'(v.funct));
    check($sformatf("v%0d pc_plus4", idx), pc_plus4, v.pc4);
    for (int s = 0; s <= v.stalls; s++) begin
      ex_stall = (s < v.stalls);
      check($sformatf("v%0d exec valid", idx), 32'(instr_valid), 32'd1);
      check($sformatf("v%0d exec req", idx), 32'(imem_req), 32'd0);
      check($sformatf("v%0d exec pc", idx), pc, v.pc);
      check($sformatf("v%0d exec instr", idx), instr, v.rdata);
      @(negedge clk);
    end
    ex_stall = 1'b0;
    pcsrc = ~v.pcsrc;
    check($sformatf("v%0d next valid", idx), 32'(instr_valid), 32'd0);
    check($sformatf("v%0d next req", idx), 32'(imem_req), 32'd1);
    check($sformatf("v%0d next addr", idx), imem_addr, v.next);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " req"}, 32'(imem_req), 32'd0);
    check({tag, " valid"}, 32'(instr_valid), 32'd0);
    check({tag, " pc"}, pc, 32'h0);
    check({tag, " addr"}, imem_addr, 32'h0);
    check({tag, " pc_plus4"}, pc_plus4, 32'h4);
    check({tag, " instr"}, instr, 32'h0);
  endtask

  initial begin
    logic [31:0] j_next;
`ifdef FETCH_JUMP_EN
    j_next = 32'h0000_0100;
`else
    j_next = 32'h0000_0104;
`endif
    //           rdata          w  s  src   pc             pc+4           op     funct  next
    vecs[0] = '{32'h0232_8020, 0, 0, 1'b0, 32'h0000_0000, 32'h0000_0004, 6'h00, 6'h20, 32'h0000_0004};
    vecs[1] = '{32'h1000_0002, 1, 0, 1'b1, 32'h0000_0004, 32'h0000_0008, 6'h04, 6'h02, 32'h0000_0010};
    vecs[2] = '{32'h1000_FFFF, 3, 2, 1'b1, 32'h0000_0010, 32'h0000_0014, 6'h04, 6'h3F, 32'h0000_0010};
    vecs[3] = '{32'h1000_FFFF, 0, 0, 1'b0, 32'h0000_0010, 32'h0000_0014, 6'h04, 6'h3F, 32'h0000_0014};
    vecs[4] = '{32'h1000_FFF9, 0, 1, 1'b1, 32'h0000_0014, 32'h0000_0018, 6'h04, 6'h39, 32'hFFFF_FFFC};
    vecs[5] = '{32'h0232_8020, 2, 0, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 6'h00, 6'h20, 32'h0000_0000};
    vecs[6] = '{32'h1000_003F, 0, 0, 1'b1, 32'h0000_0000, 32'h0000_0004, 6'h04, 6'h3F, 32'h0000_0100};
    vecs[7] = '{32'h0800_0040, 0, 0, 1'b0, 32'h0000_0100, 32'h0000_0104, 6'h02, 6'h00, j_next};

    n_tests    = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    pcsrc      = 1'b0;
    ex_stall   = 1'b0;

    // Reset held for three cycles, then the first fetch one cycle after release.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_reset_values($sformatf("rst%0d", c));
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("boot req", 32'(imem_req), 32'd1);
    check("boot addr", imem_addr, 32'h0);
    check("boot valid", 32'(instr_valid), 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_vec(i, vecs[i]);
    end

    // Reset during FETCH with a memory response pending: outputs drop without a clock edge.
    imem_ready = 1'b1;
    imem_rdata = 32'h0232_8020;
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("async fetch");
    @(negedge clk);
    rst_n = 1'b1;
    imem_ready = 1'b0;
    @(negedge clk);
    check("refetch req", 32'(imem_req), 32'd1);
    check("refetch valid", 32'(instr_valid), 32'd0);
    check("refetch addr", imem_addr, 32'h0);

    // Reset during EXEC after moving off address 0.
    run_vec(100, vecs[0]);
    imem_ready = 1'b1;
    imem_rdata = 32'h1000_0005;
    @(negedge clk);
    imem_ready = 1'b0;
    check("pre-rst valid", 32'(instr_valid), 32'd1);
    check("pre-rst pc", pc, 32'h4);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("async exec");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("exec-rst refetch addr", imem_addr, 32'h0);
    check("exec-rst refetch req", 32'(imem_req), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
